// File: rtl/video_pkg.sv
// Shared constants for the video source: 1080p60 raster timing, colour types,
// the 8-bar test pattern table and bit positions inside the blank/sync buses.
package video_pkg;

  localparam int CNT_W = 12;

  localparam int T1080_H_ACTIVE = 1920;
  localparam int T1080_H_FP     = 88;
  localparam int T1080_H_SYNC   = 44;
  localparam int T1080_H_BP     = 148;
  localparam int T1080_H_TOTAL  = T1080_H_ACTIVE + T1080_H_FP + T1080_H_SYNC + T1080_H_BP;

  localparam int T1080_V_ACTIVE = 1080;
  localparam int T1080_V_FP     = 4;
  localparam int T1080_V_SYNC   = 5;
  localparam int T1080_V_BP     = 36;
  localparam int T1080_V_TOTAL  = T1080_V_ACTIVE + T1080_V_FP + T1080_V_SYNC + T1080_V_BP;

  localparam int T1080_BAR_W    = 240;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_BLACK   = 24'h000000;

  // Bit positions in vh_blank ({Vblank, Hblank}) and dvh_sync ({D_sync, Vsync, Hsync}).
  localparam int VB_BIT = 1;
  localparam int HB_BIT = 0;
  localparam int DS_BIT = 2;
  localparam int VS_BIT = 1;
  localparam int HS_BIT = 0;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = RGB_WHITE;
      3'd1:    bar_colour = RGB_YELLOW;
      3'd2:    bar_colour = RGB_CYAN;
      3'd3:    bar_colour = RGB_GREEN;
      3'd4:    bar_colour = RGB_MAGENTA;
      3'd5:    bar_colour = RGB_RED;
      3'd6:    bar_colour = RGB_BLUE;
      default: bar_colour = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_bar_pattern.sv
// Colour bar generator: counts active pixels into fixed-width bars without a divider.
// Colour output is combinational from the bar index; the caller registers it.
module video_bar_pattern
  import video_pkg::*;
#(
  parameter int BAR_W = T1080_BAR_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic        act_i,
  input  logic        wrap_i,
  output logic [23:0] rgb_o
);

  localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAR_W - 1);

  logic [SUB_W-1:0] sub_q;
  logic [2:0]       idx_q;

  // The index wraps 7 -> 0 on its own at the end of the active line; the line
  // wrap clear keeps both counters aligned even if a line was cut short by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sub_q <= '0;
      idx_q <= '0;
    end else if (cen_i) begin
      if (wrap_i) begin
        sub_q <= '0;
        idx_q <= '0;
      end else if (act_i) begin
        if (sub_q == SUB_LAST) begin
          sub_q <= '0;
          idx_q <= idx_q + 3'd1;
        end else begin
          sub_q <= sub_q + SUB_W'(1);
        end
      end
    end
  end

  assign rgb_o = bar_colour(idx_q);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: h/v counters, blank/sync decode and colour bars, all outputs
// registered one enabled cycle behind the counters and mutually aligned.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = T1080_H_ACTIVE,
  parameter int H_FP     = T1080_H_FP,
  parameter int H_SYNC   = T1080_H_SYNC,
  parameter int H_BP     = T1080_H_BP,
  parameter int V_ACTIVE = T1080_V_ACTIVE,
  parameter int V_FP     = T1080_V_FP,
  parameter int V_SYNC   = T1080_V_SYNC,
  parameter int V_BP     = T1080_V_BP,
  parameter int SYNC_POL = 1,
  parameter int BAR_W    = T1080_BAR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cen_i,
  output logic [23:0]      vid_rgb_o,
  output logic [1:0]       vh_blank_o,
  output logic [2:0]       dvh_sync_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic       SYNC_INV  = (SYNC_POL == 0);
  localparam logic [2:0] SYNC_IDLE = {1'b0, SYNC_INV, SYNC_INV};

  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;
  logic             h_last;
  logic             v_last;
  logic             hblank;
  logic             vblank;
  logic             hsync;
  logic             vsync;
  logic             de;
  rgb_t             bar_rgb;
  logic [1:0]       blank_d;
  logic [2:0]       sync_d;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign hblank = (h_q >= H_ACT);
  assign vblank = (v_q >= V_ACT);
  assign hsync  = (h_q >= HS_START) && (h_q < HS_END);
  // v only moves on the h wrap, so vsync naturally switches on whole lines.
  assign vsync  = (v_q >= VS_START) && (v_q < VS_END);
  assign de     = ~hblank & ~vblank;

  always_comb begin
    blank_d         = '0;
    blank_d[VB_BIT] = vblank;
    blank_d[HB_BIT] = hblank;
    sync_d          = '0;
    sync_d[DS_BIT]  = de;
    sync_d[VS_BIT]  = vsync ^ SYNC_INV;
    sync_d[HS_BIT]  = hsync ^ SYNC_INV;
  end

  video_bar_pattern #(
    .BAR_W (BAR_W)
  ) u_bars (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cen_i  (cen_i),
    .act_i  (de),
    .wrap_i (h_last),
    .rgb_o  (bar_rgb)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q           <= '0;
      v_q           <= '0;
      vid_rgb_o     <= '0;
      vh_blank_o    <= 2'b11;
      dvh_sync_o    <= SYNC_IDLE;
      h_cnt_o       <= '0;
      v_cnt_o       <= '0;
      frame_start_o <= 1'b0;
    end else if (cen_i) begin
      h_q <= h_last ? '0 : h_q + CNT_W'(1);
      if (h_last) begin
        v_q <= v_last ? '0 : v_q + CNT_W'(1);
      end
      vid_rgb_o     <= de ? bar_rgb : RGB_BLACK;
      vh_blank_o    <= blank_d;
      dvh_sync_o    <= sync_d;
      h_cnt_o       <= h_q;
      v_cnt_o       <= v_q;
      frame_start_o <= (h_q == '0) && (v_q == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a full 1080p instance plus two reduced-geometry instances (both sync polarities).
module tb_video_timing_gen;

  typedef struct packed {
    logic [23:0] rgb;
    logic [1:0]  blank;
    logic [2:0]  sync;
    logic [11:0] h;
    logic [11:0] v;
    logic        fs;
  } obs_t;

  // kind: 0 = held (cen low), 1 = enabled advance, 2 = reset
  typedef struct packed {
    logic [1:0] kind;
    obs_t       o;
  } sb_t;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, bw, pol;
  } geom_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cen = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] rgb0, rgb1, rgb2;
  logic [1:0]  bl0, bl1, bl2;
  logic [2:0]  sy0, sy1, sy2;
  logic [11:0] hc0, hc1, hc2, vc0, vc1, vc2;
  logic        fs0, fs1, fs2;

  video_timing_gen u_big (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .vid_rgb_o(rgb0), .vh_blank_o(bl0),
    .dvh_sync_o(sy0), .h_cnt_o(hc0), .v_cnt_o(vc0), .frame_start_o(fs0));

  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1),
                     .V_SYNC(2), .V_BP(2), .SYNC_POL(1), .BAR_W(2)) u_small (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .vid_rgb_o(rgb1), .vh_blank_o(bl1),
    .dvh_sync_o(sy1), .h_cnt_o(hc1), .v_cnt_o(vc1), .frame_start_o(fs1));

  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(1),
                     .V_SYNC(2), .V_BP(2), .SYNC_POL(0), .BAR_W(2)) u_small_n (
    .clk_i(clk), .rst_i(rst), .cen_i(cen), .vid_rgb_o(rgb2), .vh_blank_o(bl2),
    .dvh_sync_o(sy2), .h_cnt_o(hc2), .v_cnt_o(vc2), .frame_start_o(fs2));

  int n_vec = 0;
  int n_bad = 0;

  logic [23:0] bars [8];
  geom_t g [3];
  int    mh [3];
  int    mv [3];
  obs_t  last [3];
  sb_t   q0 [$];
  sb_t   q1 [$];
  sb_t   q2 [$];

  function automatic obs_t decode(geom_t gg, int h, int v);
    obs_t o;
    bit hb, vb, hs, vs, inv;
    hb  = (h >= gg.ha);
    vb  = (v >= gg.va);
    hs  = (h >= gg.ha + gg.hfp) && (h < gg.ha + gg.hfp + gg.hs);
    vs  = (v >= gg.va + gg.vfp) && (v < gg.va + gg.vfp + gg.vs);
    inv = (gg.pol == 0);
    o.rgb   = (!hb && !vb) ? bars[h / gg.bw] : 24'h0;
    o.blank = {vb, hb};
    o.sync  = {!hb && !vb, vs ^ inv, hs ^ inv};
    o.h     = 12'(h);
    o.v     = 12'(v);
    o.fs    = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t reset_obs(geom_t gg);
    obs_t o;
    bit inv;
    inv     = (gg.pol == 0);
    o.rgb   = 24'h0;
    o.blank = 2'b11;
    o.sync  = {1'b0, inv, inv};
    o.h     = 12'd0;
    o.v     = 12'd0;
    o.fs    = 1'b0;
    return o;
  endfunction

  task automatic push_exp(input bit r, input bit c);
    sb_t s;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        s.kind = 2'd2; s.o = reset_obs(g[i]); mh[i] = 0; mv[i] = 0;
      end else if (c) begin
        s.kind = 2'd1; s.o = decode(g[i], mh[i], mv[i]);
        mh[i]++;
        if (mh[i] == g[i].ha + g[i].hfp + g[i].hs + g[i].hbp) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == g[i].va + g[i].vfp + g[i].vs + g[i].vbp) mv[i] = 0;
        end
      end else begin
        s.kind = 2'd0; s.o = last[i];
      end
      last[i] = s.o;
      case (i)
        0:       q0.push_back(s);
        1:       q1.push_back(s);
        default: q2.push_back(s);
      endcase
    end
  endtask

  task automatic step(input bit r, input bit c);
    rst = r;
    cen = c;
    push_exp(r, c);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input obs_t a, input obs_t e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got rgb=%h blank=%b sync=%b h=%0d v=%0d fs=%b, want rgb=%h blank=%b sync=%b h=%0d v=%0d fs=%b",
               nm, a.rgb, a.blank, a.sync, a.h, a.v, a.fs, e.rgb, e.blank, e.sync, e.h, e.v, e.fs);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, a, e);
    end
  endtask

  // Monitor: pops one expected entry per instance each cycle, plus line/frame statistics.
  int hb_cnt, hs_cnt, hs_first;
  bit line_ok = 1'b0;
  int f_cnt = 0;
  bit f_prev = 1'b0;
  int vs_min = 9999;
  int vs_max = -1;

  initial begin
    sb_t  s;
    obs_t a;
    logic [28:0] hv;
    bit hit;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        s = q0.pop_front();
        a = {rgb0, bl0, sy0, hc0, vc0, fs0};
        chk("big", a, s.o);
        if (s.kind == 2'd2) line_ok = 1'b0;
        if (s.kind == 2'd1) begin
          hit = 1'b1;
          case (s.o.h)
            12'd0, 12'd239: hv = {24'hFFFFFF, 2'b00, 3'b100};
            12'd240:        hv = {24'hFFFF00, 2'b00, 3'b100};
            12'd1919:       hv = {24'h000000, 2'b00, 3'b100};
            12'd1920:       hv = {24'h000000, 2'b01, 3'b000};
            12'd2007:       hv = {24'h000000, 2'b01, 3'b000};
            12'd2008:       hv = {24'h000000, 2'b01, 3'b001};
            12'd2051:       hv = {24'h000000, 2'b01, 3'b001};
            12'd2052:       hv = {24'h000000, 2'b01, 3'b000};
            12'd2199:       hv = {24'h000000, 2'b01, 3'b000};
            default: begin hit = 1'b0; hv = '0; end
          endcase
          if (hit && s.o.v == 12'd0) begin
            n_vec++;
            if ({a.rgb, a.blank, a.sync} !== hv) begin
              n_bad++;
              $display("FAIL line0_px%0d: got rgb=%h blank=%b sync=%b, want %h", s.o.h, a.rgb, a.blank, a.sync, hv);
            end
          end
          if (s.o.h == 12'd0) begin
            line_ok = 1'b1; hb_cnt = 0; hs_cnt = 0; hs_first = -1;
          end
          if (line_ok) begin
            hb_cnt += int'(a.blank[0]);
            if (a.sync[0]) begin
              hs_cnt++;
              if (hs_first < 0) hs_first = int'(s.o.h);
            end
            if (s.o.h == 12'd2199) begin
              chk_int("hblank_len", hb_cnt, 280);
              chk_int("hsync_len", hs_cnt, 44);
              chk_int("hsync_start", hs_first, 2008);
            end
          end
        end
      end
      if (q1.size() > 0) begin
        s = q1.pop_front();
        a = {rgb1, bl1, sy1, hc1, vc1, fs1};
        chk("small", a, s.o);
        if (s.kind == 2'd2) begin f_prev = 1'b0; vs_min = 9999; vs_max = -1; end
        if (s.kind == 2'd1) begin
          f_cnt++;
          if (a.sync[1]) begin
            if (int'(s.o.v) < vs_min) vs_min = int'(s.o.v);
            if (int'(s.o.v) > vs_max) vs_max = int'(s.o.v);
          end
          if (a.fs) begin
            if (f_prev) begin
              chk_int("frame_period", f_cnt, 275);
              chk_int("vsync_first_line", vs_min, 7);
              chk_int("vsync_last_line", vs_max, 8);
            end
            f_cnt = 0; f_prev = 1'b1; vs_min = 9999; vs_max = -1;
          end
        end
      end
      if (q2.size() > 0) begin
        s = q2.pop_front();
        a = {rgb2, bl2, sy2, hc2, vc2, fs2};
        chk("small_negpol", a, s.o);
      end
    end
  end

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    g[0] = '{ha:1920, hfp:88, hs:44, hbp:148, va:1080, vfp:4, vs:5, vbp:36, bw:240, pol:1};
    g[1] = '{ha:16, hfp:2, hs:3, hbp:4, va:6, vfp:1, vs:2, vbp:2, bw:2, pol:1};
    g[2] = '{ha:16, hfp:2, hs:3, hbp:4, va:6, vfp:1, vs:2, vbp:2, bw:2, pol:0};
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0; mv[i] = 0; last[i] = '0;
    end

    step(1'b1, 1'b1);
    for (int k = 0; k < 6700; k++) step(1'b0, 1'b1);

    for (int k = 0; k < 900; k++) step(1'b0, (k % 3) == 0);

    for (int k = 0; k < 400 && !(mh[1] == 10 && mv[1] == 5); k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    for (int k = 0; k < 600; k++) step(1'b0, 1'b1);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
